// File: rtl/lcd_bus_arbiter.sv
// Arbiter sharing the lcd_interface command port between lcd_init (until init_finish) and lcd_id.
// Optional watchdog on WAIT_BUSY/WAIT_DONE enabled by defining LCD_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module lcd_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned BUSY_WAIT_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_we,
    input  logic        init_wr,
    input  logic        init_rs,
    input  logic [15:0] init_data,
    input  logic        init_finish,
    output logic        init_write_ok,
    input  logic        id_we,
    input  logic        id_wr,
    input  logic        id_lcd_rs,
    input  logic [15:0] id_data,
    input  logic        id_fm,
    input  logic        id_read_color,
    output logic        id_busy,
    output logic        id_write_color_ok,
    output logic [15:0] intf_data,
    output logic        intf_we,
    output logic        intf_wr,
    output logic        intf_lcd_rs,
    output logic        intf_id_fm,
    output logic        intf_read_color,
    input  logic        intf_busy,
    input  logic        intf_init_write_ok,
    input  logic        intf_write_color_ok,
    output logic        arb_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } state_e;

    typedef enum logic {
        OWN_INIT = 1'b0,
        OWN_ID   = 1'b1
    } owner_e;

    typedef struct packed {
        logic        wr;
        logic        rs;
        logic        fm;
        logic        rc;
        logic [15:0] data;
    } cmd_t;

    localparam int BW_W = (BUSY_WAIT_MAX > 2) ? $clog2(BUSY_WAIT_MAX) : 1;
    localparam logic [BW_W-1:0] BW_LAST = BW_W'(BUSY_WAIT_MAX - 1);

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    cmd_t            cmd_q, cmd_d;
    logic [BW_W-1:0] bw_cnt_q, bw_cnt_d;
    logic            ack_seen_q, ack_seen_d;
    logic            we_q, we_d;
    logic            init_ok_q, init_ok_d;
    logic            id_ok_q, id_ok_d;
    logic            id_busy_q, id_busy_d;

`ifdef LCD_ARB_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        err_q, err_d;
    logic        in_wait;
    logic        timeout_hit;
    logic        err_set;

    assign in_wait     = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
    assign timeout_hit = in_wait && (to_cnt_q == TIMEOUT_CYCLES - 1);
    assign to_cnt_d    = in_wait ? to_cnt_q + 32'd1 : 32'd0;
    assign err_d       = err_q | err_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign arb_err = err_q;
`else
    assign arb_err = 1'b0;
`endif

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        bw_cnt_d   = '0;
        ack_seen_d = ack_seen_q | intf_init_write_ok | intf_write_color_ok;
`ifdef LCD_ARB_TIMEOUT_EN
        err_set    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (!init_finish && init_we) begin
                    state_d = S_ISSUE;
                    owner_d = OWN_INIT;
                    cmd_d   = '{wr: init_wr, rs: init_rs, fm: 1'b0, rc: 1'b0, data: init_data};
                end else if (init_finish && id_we) begin
                    state_d = S_ISSUE;
                    owner_d = OWN_ID;
                    cmd_d   = '{wr: id_wr, rs: id_lcd_rs, fm: id_fm, rc: id_read_color, data: id_data};
                end
            end
            S_ISSUE: begin
                // Acks left over from the previous command must not complete this one.
                ack_seen_d = 1'b0;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                bw_cnt_d = bw_cnt_q + BW_W'(1);
                if (intf_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (ack_seen_q || (bw_cnt_q == BW_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!intf_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef LCD_ARB_TIMEOUT_EN
        if (timeout_hit && (state_d != S_DONE)) begin
            state_d = S_DONE;
            err_set = 1'b1;
        end
`endif

        // Outputs are registered from the next state so they line up with state_q.
        we_d      = (state_d == S_ISSUE);
        init_ok_d = (state_d == S_DONE) && (owner_q == OWN_INIT);
        id_ok_d   = (state_d == S_DONE) && (owner_q == OWN_ID);
        id_busy_d = !init_finish || (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_INIT;
            cmd_q      <= '0;
            bw_cnt_q   <= '0;
            ack_seen_q <= 1'b0;
            we_q       <= 1'b0;
            init_ok_q  <= 1'b0;
            id_ok_q    <= 1'b0;
            id_busy_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cmd_q      <= cmd_d;
            bw_cnt_q   <= bw_cnt_d;
            ack_seen_q <= ack_seen_d;
            we_q       <= we_d;
            init_ok_q  <= init_ok_d;
            id_ok_q    <= id_ok_d;
            id_busy_q  <= id_busy_d;
        end
    end

    assign intf_we           = we_q;
    assign intf_data         = cmd_q.data;
    assign intf_wr           = cmd_q.wr;
    assign intf_lcd_rs       = cmd_q.rs;
    assign intf_id_fm        = cmd_q.fm;
    assign intf_read_color   = cmd_q.rc;
    assign init_write_ok     = init_ok_q;
    assign id_write_color_ok = id_ok_q;
    assign id_busy           = id_busy_q;

endmodule
